// File: rtl/u_uart_pkg.sv
// Shared types and constants for the u_tx arbiter slice.
// Optional header/channel-ID framing is enabled by defining U_ARB_CHID_EN.
package u_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HLOAD = 3'd1,
        ST_HWAIT = 3'd2,
        ST_LOAD  = 3'd3,
        ST_WAIT  = 3'd4
    } arb_state_e;

    localparam logic [3:0] CHID_TAG    = 4'hA;
    localparam int         DEF_TIMEOUT = 2048;

endpackage

// File: rtl/u_rr_pick.sv
// Combinational round-robin picker: first asserted request after i_ptr, wrapping modulo NREQ.
module u_rr_pick #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [3:0]      i_ptr,
    output logic [NREQ-1:0] o_gnt_onehot,
    output logic [3:0]      o_gnt_idx,
    output logic            o_any
);

    // Outer loop walks priority distance from the pointer; inner loop keeps every index constant.
    always_comb begin
        o_gnt_onehot = '0;
        o_gnt_idx    = '0;
        o_any        = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            for (int j = 0; j < NREQ; j++) begin
                if (!o_any && i_req[j] && (((int'(i_ptr) + k) % NREQ) == j)) begin
                    o_any           = 1'b1;
                    o_gnt_onehot[j] = 1'b1;
                    o_gnt_idx       = 4'(j);
                end
            end
        end
    end

endmodule

// File: rtl/u_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte producers, with frame watchdog.
// Define U_ARB_CHID_EN to prefix every granted byte with a {CHID_TAG, grant_id} header frame.
module u_tx_arbiter
    import u_uart_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NREQ-1:0]   i_req_valid,
    input  logic [NREQ*8-1:0] i_req_data,
    output logic [NREQ-1:0]   o_req_ready,
    input  logic              i_tx_busy,
    input  logic              i_tx_done,
    output logic              o_tx_start,
    output logic [7:0]        o_tx_data,
    output logic [3:0]        o_grant_id,
    output logic              o_arb_busy,
    output logic              o_err_timeout
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e       r_state;
    arb_state_e       w_next;
    logic [3:0]       r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [7:0]       r_tx_data;
    logic [3:0]       r_grant_id;
    logic [NREQ-1:0]  w_gnt_onehot;
    logic [3:0]       w_gnt_idx;
    logic             w_any;
    logic [7:0]       w_sel_data;
    logic             w_timeout;
    logic             w_accept;
`ifdef U_ARB_CHID_EN
    logic [7:0]       r_hold;
`endif

    u_rr_pick #(.NREQ(NREQ)) u_pick (
        .i_req        (i_req_valid),
        .i_ptr        (r_ptr),
        .o_gnt_onehot (w_gnt_onehot),
        .o_gnt_idx    (w_gnt_idx),
        .o_any        (w_any)
    );

    always_comb begin
        w_sel_data = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_gnt_onehot[j]) begin
                w_sel_data = i_req_data[8*j +: 8];
            end
        end
    end

    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));
    assign w_accept  = (r_state == ST_IDLE) && w_any;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // tx_done beats a simultaneous watchdog expiry; tx_done outside the wait states is ignored.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
`ifdef U_ARB_CHID_EN
                    w_next = ST_HLOAD;
`else
                    w_next = ST_LOAD;
`endif
                end
            end
`ifdef U_ARB_CHID_EN
            ST_HLOAD: begin
                if (!i_tx_busy) begin
                    w_next = ST_HWAIT;
                end
            end
            ST_HWAIT: begin
                if (i_tx_done) begin
                    w_next = ST_LOAD;
                end else if (w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
`endif
            ST_LOAD: begin
                if (!i_tx_busy) begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_tx_done || w_timeout) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is asserted so nothing is accepted or started.
    always_comb begin
        o_req_ready   = '0;
        o_tx_start    = 1'b0;
        o_err_timeout = 1'b0;
        o_arb_busy    = 1'b0;
        if (!i_rst) begin
            o_arb_busy = (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE:           o_req_ready   = w_gnt_onehot;
                ST_HLOAD, ST_LOAD: o_tx_start    = !i_tx_busy;
                ST_HWAIT, ST_WAIT: o_err_timeout = w_timeout && !i_tx_done;
                default:           ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= 4'(NREQ - 1);
            r_cnt      <= '0;
            r_tx_data  <= 8'h00;
            r_grant_id <= 4'h0;
`ifdef U_ARB_CHID_EN
            r_hold     <= 8'h00;
`endif
        end else begin
            if (w_accept) begin
                r_ptr      <= w_gnt_idx;
                r_grant_id <= w_gnt_idx;
`ifdef U_ARB_CHID_EN
                r_tx_data  <= {CHID_TAG, w_gnt_idx};
                r_hold     <= w_sel_data;
`else
                r_tx_data  <= w_sel_data;
`endif
            end
`ifdef U_ARB_CHID_EN
            if ((r_state == ST_HWAIT) && i_tx_done) begin
                r_tx_data <= r_hold;
            end
`endif
            // Watchdog restarts on every tx_start and saturates rather than wrapping.
            if (o_tx_start) begin
                r_cnt <= '0;
            end else if (((r_state == ST_WAIT) || (r_state == ST_HWAIT)) && (r_cnt != {CW{1'b1}})) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_tx_data  = r_tx_data;
    assign o_grant_id = r_grant_id;

endmodule

// File: tb/tb_u_tx_arbiter.sv
// Directed, table-driven bench for u_tx_arbiter (NREQ=4, TIMEOUT=16); checks the header
// framing path instead of the plain path when U_ARB_CHID_EN is defined.
module tb_u_tx_arbiter;

   localparam int NREQ    = 4;
   localparam int TIMEOUT = 16;
   localparam logic [31:0] DATA_A = 32'hD3C2B1A0;
   localparam logic [31:0] DATA_B = 32'hD35AB1A0;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  reqValid;
   logic [31:0] reqData;
   logic [3:0]  reqReady;
   logic        txBusy;
   logic        txDone;
   logic        txStart;
   logic [7:0]  txData;
   logic [3:0]  grantId;
   logic        arbBusy;
   logic        errTimeout;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   u_tx_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req_valid   (reqValid),
      .i_req_data    (reqData),
      .o_req_ready   (reqReady),
      .i_tx_busy     (txBusy),
      .i_tx_done     (txDone),
      .o_tx_start    (txStart),
      .o_tx_data     (txData),
      .o_grant_id    (grantId),
      .o_arb_busy    (arbBusy),
      .o_err_timeout (errTimeout)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  valid;
      logic [31:0] data;
      logic        busy;
      logic        done;
      logic [3:0]  eReady;
      logic        eStart;
      logic [7:0]  eData;
      logic [3:0]  eGid;
      logic        eBusy;
      logic        eErr;
   } vec_t;

   vec_t tbl [24];

   task automatic applyStimulus(input vec_t v);
      rst      = v.rst;
      reqValid = v.valid;
      reqData  = v.data;
      txBusy   = v.busy;
      txDone   = v.done;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] packOut();
      return {13'd0, reqReady, txStart, txData, grantId, arbBusy, errTimeout};
   endfunction

   function automatic logic [31:0] packExp(input vec_t v);
      return {13'd0, v.eReady, v.eStart, v.eData, v.eGid, v.eBusy, v.eErr};
   endfunction

   initial begin
      int stallStarts;

      //                rst valid  data    busy done  ready start data  gid busy err
      tbl[0]  = '{1'b1, 4'hF, DATA_A, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 4'hF, DATA_A, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 4'hF, DATA_A, 1'b0, 1'b0, 4'h0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h0, 1'b1, 8'hA0, 4'd0, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 4'hF, DATA_A, 1'b1, 1'b0, 4'h0, 1'b0, 8'hA0, 4'd0, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 4'hF, DATA_A, 1'b1, 1'b1, 4'h0, 1'b0, 8'hA0, 4'd0, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h2, 1'b0, 8'hA0, 4'd0, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h0, 1'b1, 8'hB1, 4'd1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b1, 4'h0, 1'b0, 8'hB1, 4'd1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h4, 1'b0, 8'hB1, 4'd1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h0, 1'b1, 8'hC2, 4'd2, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b1, 4'h0, 1'b0, 8'hC2, 4'd2, 1'b1, 1'b0};
      tbl[13] = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h8, 1'b0, 8'hC2, 4'd2, 1'b0, 1'b0};
      tbl[14] = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h0, 1'b1, 8'hD3, 4'd3, 1'b1, 1'b0};
      tbl[15] = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b1, 4'h0, 1'b0, 8'hD3, 4'd3, 1'b1, 1'b0};
      tbl[16] = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h1, 1'b0, 8'hD3, 4'd3, 1'b0, 1'b0};
      tbl[17] = '{1'b0, 4'hF, DATA_A, 1'b0, 1'b0, 4'h0, 1'b1, 8'hA0, 4'd0, 1'b1, 1'b0};
      tbl[18] = '{1'b0, 4'h0, DATA_A, 1'b0, 1'b1, 4'h0, 1'b0, 8'hA0, 4'd0, 1'b1, 1'b0};
      tbl[19] = '{1'b0, 4'h0, DATA_A, 1'b0, 1'b1, 4'h0, 1'b0, 8'hA0, 4'd0, 1'b0, 1'b0};
      tbl[20] = '{1'b0, 4'h4, DATA_B, 1'b0, 1'b0, 4'h4, 1'b0, 8'hA0, 4'd0, 1'b0, 1'b0};
      tbl[21] = '{1'b0, 4'h0, DATA_B, 1'b0, 1'b0, 4'h0, 1'b1, 8'h5A, 4'd2, 1'b1, 1'b0};
      tbl[22] = '{1'b0, 4'h0, DATA_B, 1'b0, 1'b1, 4'h0, 1'b0, 8'h5A, 4'd2, 1'b1, 1'b0};
      tbl[23] = '{1'b0, 4'h0, DATA_B, 1'b0, 1'b0, 4'h0, 1'b0, 8'h5A, 4'd2, 1'b0, 1'b0};

      // One reset edge first so registered outputs are defined when the table starts.
      rst      = 1'b1;
      reqValid = 4'hF;
      reqData  = DATA_A;
      txBusy   = 1'b0;
      txDone   = 1'b0;
      nextCycle();

      // Reset rows run in every build; the remaining rows describe the single-frame path.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(tbl[i]);
         #1;
         checkOutput($sformatf("vec%0d", i), packOut(), packExp(tbl[i]));
         nextCycle();
      end

`ifndef U_ARB_CHID_EN
      for (int i = 3; i < 24; i++) begin
         applyStimulus(tbl[i]);
         #1;
         checkOutput($sformatf("vec%0d", i), packOut(), packExp(tbl[i]));
         nextCycle();
      end

      // u_tx stays busy after the accept; tx_start must hold off until it goes idle.
      reqValid = 4'h1;
      reqData  = DATA_A;
      txBusy   = 1'b1;
      #1;
      checkOutput("busyAccept", {28'd0, reqReady}, 32'h1);
      nextCycle();
      reqValid    = 4'h0;
      stallStarts = 0;
      for (int c = 0; c < 50; c++) begin
         #1;
         if (txStart) stallStarts++;
         nextCycle();
      end
      checkOutput("busyNoStart", stallStarts, 0);
      txBusy = 1'b0;
      #1;
      checkOutput("busyRelease", {23'd0, txStart, txData}, {23'd0, 1'b1, 8'hA0});
      nextCycle();
      txDone = 1'b1;
      #1;
      checkOutput("busyWaitState", {31'd0, arbBusy}, 32'h1);
      nextCycle();
      txDone = 1'b0;

      // Watchdog expires 16 cycles after tx_start when tx_done never comes.
      reqValid = 4'h2;
      #1;
      checkOutput("toAccept", {28'd0, reqReady}, 32'h2);
      nextCycle();
      reqValid = 4'h0;
      #1;
      checkOutput("toStart", {31'd0, txStart}, 32'h1);
      nextCycle();
      for (int k = 1; k <= 16; k++) begin
         #1;
         checkOutput($sformatf("toErr%0d", k), {31'd0, errTimeout}, (k == 16) ? 32'h1 : 32'h0);
         nextCycle();
      end
      #1;
      checkOutput("toIdle", {31'd0, arbBusy}, 32'h0);

      // Same again but tx_done lands exactly on the expiry cycle: no error.
      reqValid = 4'h2;
      #1;
      checkOutput("doneAccept", {28'd0, reqReady}, 32'h2);
      nextCycle();
      reqValid = 4'h0;
      #1;
      checkOutput("doneStart", {31'd0, txStart}, 32'h1);
      nextCycle();
      for (int k = 1; k <= 16; k++) begin
         txDone = (k == 16);
         #1;
         checkOutput($sformatf("doneErr%0d", k), {31'd0, errTimeout}, 32'h0);
         nextCycle();
      end
      txDone = 1'b0;
      #1;
      checkOutput("doneIdle", {31'd0, arbBusy}, 32'h0);

      // Reset in the middle of a frame returns to IDLE and rewinds the pointer.
      reqValid = 4'h4;
      #1;
      checkOutput("rstAccept", {28'd0, reqReady}, 32'h4);
      nextCycle();
      reqValid = 4'h0;
      nextCycle();
      rst = 1'b1;
      #1;
      checkOutput("rstGated", {25'd0, reqReady, txStart, arbBusy, errTimeout}, 32'h0);
      nextCycle();
      rst = 1'b0;
      #1;
      checkOutput("rstMidWait", {19'd0, txData, grantId, arbBusy}, 32'h0);
      reqValid = 4'hF;
      #1;
      checkOutput("rstPtr", {28'd0, reqReady}, 32'h1);
      nextCycle();
      reqValid = 4'h0;
`else
      // Requester 3 sends 8'hC3: header 8'hA3 goes out first, then the data byte.
      rst      = 1'b0;
      reqValid = 4'h8;
      reqData  = 32'hC3000000;
      #1;
      checkOutput("hdrAccept", {28'd0, reqReady}, 32'h8);
      nextCycle();
      reqValid = 4'h0;
      #1;
      checkOutput("hdrStart", {19'd0, txStart, txData, grantId}, {19'd0, 1'b1, 8'hA3, 4'd3});
      nextCycle();
      txBusy = 1'b1;
      #1;
      checkOutput("hdrHold", {23'd0, txStart, txData}, {23'd0, 1'b0, 8'hA3});
      txBusy = 1'b0;
      txDone = 1'b1;
      #1;
      checkOutput("hdrDone", {23'd0, errTimeout, txData}, {23'd0, 1'b0, 8'hA3});
      nextCycle();
      txDone = 1'b0;
      #1;
      checkOutput("dataStart", {23'd0, txStart, txData}, {23'd0, 1'b1, 8'hC3});
      nextCycle();
      txDone = 1'b1;
      #1;
      checkOutput("dataWait", {31'd0, arbBusy}, 32'h1);
      nextCycle();
      txDone = 1'b0;
      #1;
      checkOutput("dataIdle", {31'd0, arbBusy}, 32'h0);

      // Reset while the header frame is in flight.
      reqValid = 4'h1;
      #1;
      checkOutput("rstAccept", {28'd0, reqReady}, 32'h1);
      nextCycle();
      reqValid = 4'h0;
      nextCycle();
      rst = 1'b1;
      nextCycle();
      rst = 1'b0;
      #1;
      checkOutput("rstMidWait", {19'd0, txData, grantId, arbBusy}, 32'h0);
      reqValid = 4'hF;
      #1;
      checkOutput("rstPtr", {28'd0, reqReady}, 32'h1);
      nextCycle();
      reqValid = 4'h0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
